// File: rtl/ace_master_fsm.sv
// ACE master control: transaction FSM (AW/W/B and AR/R with retry and stall
// timeout) alongside a snoop responder FSM, concurrent or mutually exclusive.
module ace_master_fsm #(
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT     = 256,
  parameter int SNOOP_BLOCK = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  output logic [1:0] op_sel,
  output logic       done,
  output logic       err,
  input  logic       resp_okay,
  output logic       read_resp_en,
  output logic       AW_VALID,
  output logic       W_VALID,
  output logic       B_READY,
  output logic       AR_VALID,
  output logic       R_READY,
  output logic       CR_VALID,
  output logic       CD_VALID,
  output logic       AC_READY,
  input  logic       AW_READY,
  input  logic       W_READY,
  input  logic       B_VALID,
  input  logic       AR_READY,
  input  logic       R_VALID,
  input  logic       CR_READY,
  input  logic       CD_READY,
  input  logic       AC_VALID,
  output logic       ac_enable,
  input  logic [1:0] snoop_kind,
  output logic       snoop_busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WDATA = 3'd2,
    BRESP = 3'd3,
    RADDR = 3'd4,
    RDATA = 3'd5
  } txn_state_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_CR    = 2'd2,
    S_CRCD  = 2'd3
  } snp_state_e;

  localparam logic [3:0]  MAX_RETRY_C = 4'(MAX_RETRY);
  // Abort fires on the cycle whose increment would make the counter TIMEOUT-1.
  localparam logic [15:0] TMO_LAST_C  = 16'(TIMEOUT - 2);
  localparam logic        BLOCK_C     = (SNOOP_BLOCK != 0);

  txn_state_e  txn_q, txn_d;
  snp_state_e  snp_q, snp_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] tmo_q, tmo_d;
  logic [1:0]  op_sel_q, op_sel_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        cr_done_q, cr_done_d;
  logic        cd_done_q, cd_done_d;

  logic        txn_idle_s;
  logic        snp_idle_s;
  logic        req_ready_s;
  logic        ac_ready_s;
  logic        accept_s;
  logic        ac_enable_s;
  logic        cr_now_s;
  logic        cd_now_s;

  assign txn_idle_s  = (txn_q == IDLE);
  assign snp_idle_s  = (snp_q == S_IDLE);
  // Readies are gated by rst_n so nothing handshakes while reset is held.
  assign ac_ready_s  = rst_n & snp_idle_s & (~BLOCK_C | txn_idle_s);
  assign req_ready_s = rst_n & txn_idle_s & (~BLOCK_C | (snp_idle_s & ~AC_VALID));
  assign accept_s    = req_valid & req_ready_s & (req_op != 2'b11);

  // Transaction next-state, retry bookkeeping and stall timeout.
  always_comb begin
    txn_d    = txn_q;
    retry_d  = retry_q;
    tmo_d    = tmo_q;
    op_sel_d = op_sel_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (txn_q)
      IDLE: begin
        if (accept_s) begin
          op_sel_d = req_op;
          retry_d  = 4'd0;
          txn_d    = (req_op == 2'b10) ? WADDR : RADDR;
        end else begin
          txn_d = IDLE;
        end
      end
      WADDR: begin
        if (AW_READY) txn_d = WDATA;
        else          txn_d = WADDR;
      end
      WDATA: begin
        if (W_READY) txn_d = BRESP;
        else         txn_d = WDATA;
      end
      BRESP: begin
        if (B_VALID) begin
          if (resp_okay) begin
            txn_d  = IDLE;
            done_d = 1'b1;
          end else if (retry_q < MAX_RETRY_C) begin
            retry_d = retry_q + 4'd1;
            txn_d   = WADDR;
          end else begin
            txn_d = IDLE;
            err_d = 1'b1;
          end
        end else begin
          txn_d = BRESP;
        end
      end
      RADDR: begin
        if (AR_READY) txn_d = RDATA;
        else          txn_d = RADDR;
      end
      RDATA: begin
        if (R_VALID) begin
          if (resp_okay) begin
            txn_d  = IDLE;
            done_d = 1'b1;
          end else if (retry_q < MAX_RETRY_C) begin
            retry_d = retry_q + 4'd1;
            txn_d   = RADDR;
          end else begin
            txn_d = IDLE;
            err_d = 1'b1;
          end
        end else begin
          txn_d = RDATA;
        end
      end
      default: begin
        txn_d = IDLE;
      end
    endcase
    // Every handshake moves the FSM, so a state change doubles as the clear.
    if (txn_q == IDLE) begin
      tmo_d = 16'd0;
    end else if (txn_d != txn_q) begin
      tmo_d = 16'd0;
    end else if (tmo_q == TMO_LAST_C) begin
      txn_d = IDLE;
      err_d = 1'b1;
      tmo_d = 16'd0;
    end else begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  // Snoop responder next-state; CR and CD completions tracked separately.
  always_comb begin
    snp_d       = snp_q;
    cr_done_d   = cr_done_q;
    cd_done_d   = cd_done_q;
    ac_enable_s = 1'b0;
    cr_now_s    = cr_done_q | CR_READY;
    cd_now_s    = cd_done_q | CD_READY;
    case (snp_q)
      S_IDLE: begin
        cr_done_d = 1'b0;
        cd_done_d = 1'b0;
        if (AC_VALID && ac_ready_s) begin
          ac_enable_s = 1'b1;
          snp_d       = S_CHECK;
        end else begin
          snp_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (snoop_kind == 2'b10) snp_d = S_CRCD;
        else                     snp_d = S_CR;
      end
      S_CR: begin
        if (CR_READY) snp_d = S_IDLE;
        else          snp_d = S_CR;
      end
      S_CRCD: begin
        cr_done_d = cr_now_s;
        cd_done_d = cd_now_s;
        if (cr_now_s && cd_now_s) snp_d = S_IDLE;
        else                      snp_d = S_CRCD;
      end
      default: begin
        snp_d = S_IDLE;
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_q     <= IDLE;
      snp_q     <= S_IDLE;
      retry_q   <= 4'd0;
      tmo_q     <= 16'd0;
      op_sel_q  <= 2'b00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cr_done_q <= 1'b0;
      cd_done_q <= 1'b0;
    end else begin
      txn_q     <= txn_d;
      snp_q     <= snp_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      op_sel_q  <= op_sel_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cr_done_q <= cr_done_d;
      cd_done_q <= cd_done_d;
    end
  end

  assign req_ready    = req_ready_s;
  assign op_sel       = op_sel_q;
  assign done         = done_q;
  assign err          = err_q;
  assign AW_VALID     = (txn_q == WADDR);
  assign W_VALID      = (txn_q == WDATA);
  assign B_READY      = (txn_q == BRESP);
  assign AR_VALID     = (txn_q == RADDR);
  assign R_READY      = (txn_q == RDATA);
  assign read_resp_en = (txn_q == RDATA) & R_VALID & resp_okay;
  assign CR_VALID     = (snp_q == S_CR) | ((snp_q == S_CRCD) & ~cr_done_q);
  assign CD_VALID     = (snp_q == S_CRCD) & ~cd_done_q;
  assign AC_READY     = ac_ready_s;
  assign ac_enable    = ac_enable_s;
  assign snoop_busy   = ~snp_idle_s;

endmodule

// File: tb/tb_ace_master_fsm.sv
// Directed bench for ace_master_fsm: one instance concurrent (SNOOP_BLOCK=0),
// one mutually exclusive (SNOOP_BLOCK=1), both TIMEOUT=8, MAX_RETRY=3.
module tb_ace_master_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid, resp_okay;
  logic [1:0] req_op, snoop_kind;
  logic       AW_READY, W_READY, B_VALID, AR_READY, R_VALID, CR_READY, CD_READY, AC_VALID;
  wire [15:0] out0, out1;

  // inputs: {kind[13:12], ACV, CDR, CRR, RVLD, ARR, BV, WR, AWR, OK, op[2:1], RV}
  localparam logic [13:0] I_NONE = 14'h0000, I_RV = 14'h0001;
  localparam logic [13:0] OP_RS = 14'h0000, OP_MU = 14'h0002, OP_WC = 14'h0004, OP_RSV = 14'h0006;
  localparam logic [13:0] I_OK = 14'h0008, I_AWR = 14'h0010, I_WR = 14'h0020, I_BV = 14'h0040;
  localparam logic [13:0] I_ARR = 14'h0080, I_RVLD = 14'h0100, I_CRR = 14'h0200, I_CDR = 14'h0400;
  localparam logic [13:0] I_ACV = 14'h0800, K_RO = 14'h1000, K_RD = 14'h2000, K_11 = 14'h3000;
  // outputs: {op_sel[15:14], busy, ac_en, ACR, CDV, CRV, RR, ARV, BR, WV, AWV, rre, err, done, req_ready}
  localparam logic [15:0] O_NONE = 16'h0000, O_REQR = 16'h0001, O_DONE = 16'h0002, O_ERR = 16'h0004;
  localparam logic [15:0] O_RRE = 16'h0008, O_AWV = 16'h0010, O_WV = 16'h0020, O_BR = 16'h0040;
  localparam logic [15:0] O_ARV = 16'h0080, O_RR = 16'h0100, O_CRV = 16'h0200, O_CDV = 16'h0400;
  localparam logic [15:0] O_ACR = 16'h0800, O_ACE = 16'h1000, O_SB = 16'h2000;
  localparam logic [15:0] OPS1 = 16'h4000, OPS2 = 16'h8000;
  localparam logic [15:0] IDL = O_REQR | O_ACR;

  ace_master_fsm #(.MAX_RETRY(3), .TIMEOUT(8), .SNOOP_BLOCK(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_ready(out0[0]), .op_sel(out0[15:14]), .done(out0[1]), .err(out0[2]),
    .resp_okay(resp_okay), .read_resp_en(out0[3]),
    .AW_VALID(out0[4]), .W_VALID(out0[5]), .B_READY(out0[6]), .AR_VALID(out0[7]),
    .R_READY(out0[8]), .CR_VALID(out0[9]), .CD_VALID(out0[10]), .AC_READY(out0[11]),
    .AW_READY(AW_READY), .W_READY(W_READY), .B_VALID(B_VALID), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .CR_READY(CR_READY), .CD_READY(CD_READY), .AC_VALID(AC_VALID),
    .ac_enable(out0[12]), .snoop_kind(snoop_kind), .snoop_busy(out0[13])
  );

  ace_master_fsm #(.MAX_RETRY(3), .TIMEOUT(8), .SNOOP_BLOCK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_ready(out1[0]), .op_sel(out1[15:14]), .done(out1[1]), .err(out1[2]),
    .resp_okay(resp_okay), .read_resp_en(out1[3]),
    .AW_VALID(out1[4]), .W_VALID(out1[5]), .B_READY(out1[6]), .AR_VALID(out1[7]),
    .R_READY(out1[8]), .CR_VALID(out1[9]), .CD_VALID(out1[10]), .AC_READY(out1[11]),
    .AW_READY(AW_READY), .W_READY(W_READY), .B_VALID(B_VALID), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .CR_READY(CR_READY), .CD_READY(CD_READY), .AC_VALID(AC_VALID),
    .ac_enable(out1[12]), .snoop_kind(snoop_kind), .snoop_busy(out1[13])
  );

  typedef struct {
    logic [13:0] in;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  int   ar_hs_cnt = 0, rre_cnt = 0, done_cnt = 0, err_cnt = 0;

  // Event counters on the concurrent instance, sampled at the active edge.
  always @(posedge clk) begin
    if (out0[7] && AR_READY) ar_hs_cnt <= ar_hs_cnt + 1;
    if (out0[3]) rre_cnt <= rre_cnt + 1;
    if (out0[1]) done_cnt <= done_cnt + 1;
    if (out0[2]) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [13:0] i, input logic [15:0] e);
    vec_t v;
    v.in  = i;
    v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [13:0] i);
    {snoop_kind, AC_VALID, CD_READY, CR_READY, R_VALID, AR_READY, B_VALID,
     W_READY, AW_READY, resp_okay, req_op, req_valid} = i;
  endtask

  task automatic run_range(input int a, input int b, input bit dut);
    for (int k = a; k < b; k++) begin
      @(negedge clk);
      drive(tbl[k].in);
      #1;
      check($sformatf("vec%0d_dut%0d", k, dut), dut ? 32'(out1) : 32'(out0), 32'(tbl[k].exp));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(I_NONE);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int s[10];
  int ar0, rre0, done0, err0;

  initial begin
    // Section 0: WriteClean, B response arrives after two BRESP cycles.
    s[0] = tbl.size();
    add(I_RV | OP_WC, IDL);
    add(I_AWR | I_WR, O_AWV | O_ACR | OPS2);
    add(I_AWR | I_WR, O_WV | O_ACR | OPS2);
    add(I_AWR | I_WR, O_BR | O_ACR | OPS2);
    add(I_BV | I_OK,  O_BR | O_ACR | OPS2);
    add(I_NONE, IDL | O_DONE | OPS2);
    add(I_NONE, IDL | OPS2);
    // Section 1: ReadShared, three failures then OKAY.
    s[1] = tbl.size();
    add(I_RV | OP_RS, IDL | OPS2);
    for (int r = 0; r < 3; r++) begin
      add(I_ARR, O_ARV | O_ACR);
      add(I_RVLD, O_RR | O_ACR);
    end
    add(I_ARR, O_ARV | O_ACR);
    add(I_RVLD | I_OK, O_RR | O_ACR | O_RRE);
    add(I_NONE, IDL | O_DONE);
    add(I_NONE, IDL);
    // Section 2: MakeUnique, four failures exhaust the retries.
    s[2] = tbl.size();
    add(I_RV | OP_MU, IDL);
    for (int r = 0; r < 4; r++) begin
      add(I_ARR, O_ARV | O_ACR | OPS1);
      add(I_RVLD, O_RR | O_ACR | OPS1);
    end
    add(I_NONE, IDL | O_ERR | OPS1);
    add(I_NONE, IDL | OPS1);
    // Section 3: AR stall timeout, then reserved opcode ignored.
    s[3] = tbl.size();
    add(I_RV | OP_RS, IDL | OPS1);
    for (int r = 0; r < 7; r++) add(I_NONE, O_ARV | O_ACR);
    add(I_NONE, IDL | O_ERR);
    add(I_NONE, IDL);
    add(I_RV | OP_RSV, IDL);
    add(I_NONE, IDL);
    // Section 4: snoop with data during RDATA, CD_READY 3 cycles after CR_READY.
    s[4] = tbl.size();
    add(I_RV | OP_RS, IDL);
    add(I_ARR, O_ARV | O_ACR);
    add(I_ACV | K_RD, O_RR | O_ACR | O_ACE);
    add(K_RD, O_RR | O_SB);
    add(I_CRR, O_RR | O_SB | O_CRV | O_CDV);
    add(I_NONE, O_RR | O_SB | O_CDV);
    add(I_NONE, O_RR | O_SB | O_CDV);
    add(I_CDR, O_RR | O_SB | O_CDV);
    add(I_RVLD | I_OK, O_RR | O_ACR | O_RRE);
    add(I_NONE, IDL | O_DONE);
    // Section 5: simultaneous accept, kind 11, same-cycle CR/CD completion.
    add(I_RV | OP_WC | I_ACV | K_RO, IDL | O_ACE);
    add(K_RO, O_AWV | O_SB | OPS2);
    add(I_AWR | I_CRR, O_AWV | O_SB | O_CRV | OPS2);
    add(I_WR, O_WV | O_ACR | OPS2);
    add(I_BV | I_OK, O_BR | O_ACR | OPS2);
    add(I_NONE, IDL | O_DONE | OPS2);
    add(I_ACV | K_11, IDL | O_ACE | OPS2);
    add(K_11, O_REQR | O_SB | OPS2);
    add(I_CRR, O_REQR | O_SB | O_CRV | OPS2);
    add(I_NONE, IDL | OPS2);
    add(I_ACV | K_RD, IDL | O_ACE | OPS2);
    add(K_RD, O_REQR | O_SB | OPS2);
    add(I_CRR | I_CDR, O_REQR | O_SB | O_CRV | O_CDV | OPS2);
    add(I_NONE, IDL | OPS2);
    // Section 6 (exclusive instance): snoop wins the tie, then write blocked out snoops.
    s[5] = tbl.size();
    add(I_RV | OP_WC | I_ACV | K_RO, O_ACR | O_ACE);
    add(I_RV | OP_WC | K_RO, O_SB);
    add(I_RV | OP_WC | I_CRR, O_SB | O_CRV);
    add(I_RV | OP_WC, IDL);
    add(I_ACV | I_AWR, O_AWV | OPS2);
    add(I_ACV, O_WV | OPS2);
    s[6] = tbl.size();

    drive(I_NONE);
    rst_n = 1'b0;
    #12;
    check("reset_dut0", 32'(out0), 32'(O_NONE));
    check("reset_dut1", 32'(out1), 32'(O_NONE));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_dut0", 32'(out0), 32'(IDL));
    check("post_reset_dut1", 32'(out1), 32'(IDL));

    for (int sec = 0; sec < 4; sec++) begin
      ar0 = ar_hs_cnt; rre0 = rre_cnt; done0 = done_cnt; err0 = err_cnt;
      run_range(s[sec], s[sec + 1], 1'b0);
      if (sec == 0) begin
        check("wc_done_once", 32'(done_cnt - done0), 32'd1);
        check("wc_no_err", 32'(err_cnt - err0), 32'd0);
      end else if (sec == 1) begin
        check("retry_ok_ar_hs", 32'(ar_hs_cnt - ar0), 32'd4);
        check("retry_ok_rre", 32'(rre_cnt - rre0), 32'd1);
        check("retry_ok_done", 32'(done_cnt - done0), 32'd1);
        check("retry_ok_err", 32'(err_cnt - err0), 32'd0);
      end else if (sec == 2) begin
        check("retry_fail_ar_hs", 32'(ar_hs_cnt - ar0), 32'd4);
        check("retry_fail_rre", 32'(rre_cnt - rre0), 32'd0);
        check("retry_fail_done", 32'(done_cnt - done0), 32'd0);
        check("retry_fail_err", 32'(err_cnt - err0), 32'd1);
      end else begin
        check("timeout_err", 32'(err_cnt - err0), 32'd1);
        check("timeout_done", 32'(done_cnt - done0), 32'd0);
      end
    end
    run_range(s[4], s[5], 1'b0);

    do_reset();
    run_range(s[5], s[6] - 1, 1'b1);
    // Last vector applied by hand so reset can be pulsed while WDATA is live.
    @(negedge clk);
    drive(tbl[s[6] - 1].in);
    #1;
    check("excl_wdata", 32'(out1), 32'(tbl[s[6] - 1].exp));
    rst_n = 1'b0;
    #1;
    check("rst_mid_wdata_dut1", 32'(out1), 32'(O_NONE));
    check("rst_mid_wdata_dut0", 32'(out0), 32'(O_NONE));
    drive(I_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_dut1", 32'(out1), 32'(IDL));
    check("rst_release_dut0", 32'(out0), 32'(IDL));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ace_master_fsm.md
ACE_MASTER_FSM -- requirements
Module: ace_master_fsm

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3, maximum re-issues of a transaction after a non-OKAY response (range 0..15).
REQ-002 SHALL have parameter TIMEOUT, default 256, cycles a channel may stall before abort (range 2..65535).
REQ-003 SHALL have parameter SNOOP_BLOCK, default 0: 0 = snoop and transaction FSMs run concurrently; 1 = mutually exclusive.
REQ-004 SHALL use one clock and an asynchronous active-low reset, with ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  cache controller request
- req_op  in  2  00 ReadShared, 01 MakeUnique, 10 WriteClean, 11 reserved (ignored, not accepted)
- req_ready  out  1  request accepted when req_valid & req_ready
- op_sel  out  2  latched opcode to datapath
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle failure pulse (retries exhausted or timeout)
- resp_okay  in  1  datapath-decoded RRESP/BRESP OKAY
- read_resp_en  out  1  datapath read-data capture strobe
- AW_VALID/W_VALID/B_READY/AR_VALID/R_READY/CR_VALID/CD_VALID/AC_READY  out  1 each  ACE handshakes
- AW_READY/W_READY/B_VALID/AR_READY/R_VALID/CR_READY/CD_READY/AC_VALID  in  1 each  ACE handshakes
- ac_enable  out  1  datapath snoop-lookup strobe
- snoop_kind  in  2  00 miss/invalid, 01 response only, 10 response+data, 11 treated as 01
- snoop_busy  out  1  snoop FSM not in S_IDLE

Function
REQ-005 Transaction FSM SHALL have states IDLE, WADDR, WDATA, BRESP, RADDR, RDATA; all channel outputs Moore-decoded from state.
REQ-006 IDLE: req_ready=1 (SNOOP_BLOCK=1: also requires snoop FSM in S_IDLE); on acceptance latch op_sel, clear retry count and timeout counter; op 10 -> WADDR, op 00/01 -> RADDR.
REQ-007 WADDR: AW_VALID=1 until AW_READY -> WDATA; WDATA: W_VALID=1 until W_READY -> BRESP; BRESP: B_READY=1 until B_VALID.
REQ-008 RADDR: AR_VALID=1 until AR_READY -> RDATA; RDATA: R_READY=1 until R_VALID.
REQ-009 On B_VALID/R_VALID with resp_okay=1: -> IDLE, done=1 the following cycle; read_resp_en=1 combinationally in the R handshake cycle only.
REQ-010 On B_VALID/R_VALID with resp_okay=0: if retry count < MAX_RETRY, increment and return to WADDR/RADDR; else -> IDLE, err=1 next cycle, done stays 0.
REQ-011 Timeout counter (16 bit) SHALL clear on every handshake and state entry, increment each non-IDLE cycle; reaching TIMEOUT-1 without handshake -> IDLE, err=1 next cycle.
REQ-012 done and err SHALL never assert together; op_sel holds until next acceptance.
REQ-013 Snoop FSM SHALL have states S_IDLE, S_CHECK, S_CR, S_CRCD; AC_READY=1 only in S_IDLE (SNOOP_BLOCK=1: also requires transaction FSM in IDLE).
REQ-014 S_IDLE: AC_VALID & AC_READY -> ac_enable=1 same cycle, -> S_CHECK.
REQ-015 S_CHECK (one cycle): snoop_kind 10 -> S_CRCD, else -> S_CR.
REQ-016 S_CR: CR_VALID=1 until CR_READY -> S_IDLE.
REQ-017 S_CRCD: CR_VALID and CD_VALID each deassert the cycle after their own handshake; -> S_IDLE the cycle after both complete (same-cycle completion allowed).
REQ-018 SNOOP_BLOCK=1 with req_valid and AC_VALID in the same cycle while both idle: snoop SHALL win, req_ready=0 that cycle.
REQ-019 SNOOP_BLOCK=0: both FSMs SHALL accept independently in the same cycle.

Reset
REQ-020 rst_n low SHALL force IDLE/S_IDLE, clear counters, op_sel=00, done=err=0, and drop every VALID/READY immediately, including mid-transaction.
REQ-021 After reset, req_ready=1, AC_READY=1, all other outputs 0.

Verification
REQ-022 WriteClean, all READYs high, B_VALID+okay after 2 cycles -> AW, W, B handshakes on consecutive states, done=1 once, err=0.
REQ-023 ReadShared, R response non-OKAY 3 times then OKAY, MAX_RETRY=3 -> 4 AR handshakes, read_resp_en=1 once, done=1; a 4th failure instead -> err=1.
REQ-024 TIMEOUT=8, AR_READY held low -> AR_VALID high 7 cycles, then IDLE, err=1, req_ready=1.
REQ-025 SNOOP_BLOCK=0, snoop kind 10 during RDATA, CD_READY 3 cycles after CR_READY -> CR_VALID drops first, CD_VALID after CD handshake, read proceeds undisturbed.
REQ-026 SNOOP_BLOCK=1, req_valid and AC_VALID same cycle -> snoop accepted, req_ready=0 until S_IDLE; rst_n pulsed during WDATA -> W_VALID low immediately.
